// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin drain of NUM_REQ input FIFOs into one output FIFO
// Per-channel forwarded-word counters are built only when FIFO_RR_PKT_COUNT_EN is defined.
module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_SIZE  = 10,
  parameter int CNT_SIZE   = 5,
  parameter int GRANT_SIZE = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  in_data,
  input  logic [NUM_REQ-1:0]            in_empty,
  output logic [NUM_REQ-1:0]            in_rd_en,
  input  logic                          out_almost_full,
  output logic [WORD_SIZE-1:0]          out_data,
  output logic                          out_wr_en,
  output logic [GRANT_SIZE-1:0]         grant_id,
  output logic [1:0]                    state,
  output logic                          idle_out,
  output logic [NUM_REQ*CNT_SIZE-1:0]   pkt_count
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam logic [GRANT_SIZE-1:0] LAST = GRANT_SIZE'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [GRANT_SIZE-1:0] ptr_q, ptr_d;
  logic [GRANT_SIZE-1:0] grant_q, grant_d;
  logic                  pend_q, pend_d;
  logic [NUM_REQ-1:0]    popped_q, popped_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [GRANT_SIZE-1:0] pick;
  logic [GRANT_SIZE-1:0] idx;
  logic                  found;
  logic                  issue;
  logic [WORD_SIZE-1:0]  words [NUM_REQ];

  // A channel popped last cycle still shows its stale registered empty flag.
  assign eligible = ~in_empty & ~popped_q;

  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign issue = (state_q == ST_ACTIVE) && !out_almost_full && !init && found;

  always_comb begin
    popped_d = '0;
    if (issue) begin
      popped_d[pick] = 1'b1;
    end
    pend_d  = issue;
    grant_d = issue ? pick : grant_q;
    ptr_d   = issue ? pick : ptr_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init) state_d = ST_INIT;
        else if ((|eligible) && !out_almost_full) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init) state_d = ST_INIT;
        else if (!(|eligible) && !pend_q) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RESET;
      ptr_q    <= LAST;
      grant_q  <= '0;
      pend_q   <= 1'b0;
      popped_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      pend_q   <= pend_d;
      popped_q <= popped_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = in_data[g*WORD_SIZE +: WORD_SIZE];
  end

  assign in_rd_en  = popped_d;
  assign out_wr_en = pend_q;
  // Gated so the bus reads zero whenever nothing is being pushed.
  assign out_data  = pend_q ? words[grant_q] : '0;
  assign grant_id  = grant_q;
  assign state     = state_q;
  assign idle_out  = (state_q == ST_IDLE);

`ifdef FIFO_RR_PKT_COUNT_EN
  logic [CNT_SIZE-1:0] cnt_q [NUM_REQ];
  logic [CNT_SIZE-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == ST_INIT) begin
        cnt_d[i] = '0;
      end else if (pend_q && (grant_q == GRANT_SIZE'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign pkt_count[g*CNT_SIZE +: CNT_SIZE] = cnt_q[g];
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin scheduler that drains NUM_REQ per-channel input FIFOs into one shared output FIFO, one word per cycle.
- Drives the input FIFOs' rd_en and the output FIFO's wr_en.
- Honours empty flags on the inputs and almost-full backpressure on the output.
- Sits between the per-VC FIFOs and the transaction-layer output FIFO.
- Also keeps per-channel forwarded-word counters.

Parameters:
- NUM_REQ, 4: number of input FIFOs (requesters); must be 2 or more.
- WORD_SIZE, 10: FIFO word width.
- CNT_SIZE, 5: width of each per-channel word counter.
- GRANT_SIZE, $clog2(NUM_REQ): width of grant_id.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  holds the block in INIT; clears counters.
- in_data  input  NUM_REQ*WORD_SIZE  input FIFO data_out buses; requester i at [i*WORD_SIZE +: WORD_SIZE].
- in_empty  input  NUM_REQ  input FIFO empty_flag per requester.
- in_rd_en  output  NUM_REQ  pop strobes to input FIFOs; one-hot or zero.
- out_almost_full  input  1  output FIFO almost_full_flag.
- out_data  output  WORD_SIZE  word pushed to the output FIFO.
- out_wr_en  output  1  push strobe to the output FIFO.
- grant_id  output  GRANT_SIZE  requester of the word currently on out_data.
- state  output  2  FSM state encoding.
- idle_out  output  1  high when state is IDLE.
- pkt_count  output  NUM_REQ*CNT_SIZE  per-requester forwarded-word count.

Behaviour:
- Reset (asynchronous, high):
  - state = RESET.
  - in_rd_en = 0, out_wr_en = 0, out_data = 0, grant_id = 0, idle_out = 0, pkt_count = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Internal pop-pending register = 0.
  - Any word in flight is lost.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3. Transitions:
  - RESET -> INIT on the first clock after reset deasserts.
  - INIT: stay while init=1; on init=0 -> IDLE. Counters are held at 0 in INIT.
  - From any non-RESET state, init=1 -> INIT on the next edge.
  - IDLE -> ACTIVE when at least one requester is eligible and out_almost_full=0.
  - ACTIVE -> IDLE when no requester is eligible and no pop is pending.
- Eligibility of requester i in cycle t: in_empty[i]=0 AND i was not popped in cycle t-1. The input FIFO flags are registered and lag the pointers by one cycle; this is the guard against that lag.
- Grant:
  - In ACTIVE with out_almost_full=0, search from pointer+1 upward, modulo NUM_REQ.
  - Grant the first eligible requester g.
  - Assert in_rd_en[g] combinationally in that cycle.
  - Pointer <= g at the clock edge.
  - No pop is issued in IDLE, INIT or RESET, or when out_almost_full=1.
- Datapath:
  - Input FIFO read data is valid the cycle after rd_en.
  - On a pop in cycle t, register pending=1 and grant_id=g.
  - In cycle t+1: out_wr_en = pending (registered), and out_data = in_data slice selected by grant_id (combinational mux).
  - Throughput: 1 word/cycle with 2+ non-empty requesters; every other cycle with a single non-empty requester.
- Backpressure:
  - out_almost_full is sampled at pop issue.
  - At most one word is in flight, so the output FIFO almost-full threshold must be at most DEPTH-1.
  - The in-flight word is always pushed.
- init asserted while a pop is pending: that word is still pushed at t+1 and still counted; no new pops are issued.
- Counters:
  - pkt_count[grant_id] increments on each out_wr_en.
  - Each counter saturates at 2^CNT_SIZE-1.
  - All counters clear in INIT.

Optional Feature:
- Macro: FIFO_RR_PKT_COUNT_EN.
- Defined: pkt_count counters are implemented as described.
- Undefined: counter logic is omitted, pkt_count is tied to 0, and all other behaviour is unchanged.

Test Plan:
- Reset then init=1 for 2 cycles, then 0: state goes 0 -> 1 -> 1 -> 2; all strobes stay 0; pkt_count=0.
- All 4 input FIFOs loaded with 3 words each, out_almost_full=0: pop order 0,1,2,3,0,1,2,3,...; out_wr_en high for 12 consecutive cycles, each one cycle after its in_rd_en; data order preserved per channel; state returns to 2.
- Only requester 2 non-empty with 4 words: in_rd_en[2] pulses every other cycle, never on back-to-back cycles; 4 pushes total; pkt_count[2]=4 (with the macro defined).
- Force out_almost_full=1 mid-stream: no in_rd_en from the next cycle; the single pending word is still pushed; popping resumes at the next requester in rotation after release.
- Assert init while a pop is pending: the in-flight word is pushed on the next cycle, then state=1 and counters clear; reset mid-ACTIVE clears all outputs immediately without waiting for clk.
- 40 words through requester 0 with CNT_SIZE=5: pkt_count[0] saturates at 31.
